demux4_stream: RTL and testbench
================================

// Module: demux4_stream
// PURPOSE
//  Registered 1-to-4 demultiplexer with valid/ready handshake on every port.
//  Routes one W-bit input beat to the output channel chosen by din_sel.
//  Each channel holds the beat in a one-entry slot until that channel accepts it.
//  Sits in the EB datapath opposite the ALU 4:1 select muxes: it fans a result
//  out to one of four consumers (register write-back, memory, PC, debug).
// PARAMETERS
//  W       8   data width in bits
// PORTS
//  clk         in   1    system clock, rising edge
//  rst         in   1    asynchronous reset, active-high
//  flush       in   1    synchronous clear of all channel slots
//  din         in   W    input data
//  din_sel     in   2    destination channel 0..3, sampled with din_valid
//  din_valid   in   1    input beat present
//  din_ready   out  1    block accepts the beat this cycle
//  dout0..3    out  W    channel data, one port per channel
//  dout_valid  out  4    bit i: channel i slot holds a beat
//  dout_ready  in   4    bit i: consumer i takes the beat this cycle
//  busy        out  1    OR of dout_valid
// BEHAVIOUR
//  Reset: dout_valid=0, dout0..3=0, busy=0. rst asserted mid-transfer discards all
//   slots immediately; din_ready is 0 while rst is high.
//  Transfer rules: input beat accepted when din_valid & din_ready at a clock edge.
//   Channel i beat consumed when dout_valid[i] & dout_ready[i] at a clock edge.
//  din_ready (combinational) = !flush & (!dout_valid[din_sel] | dout_ready[din_sel]).
//   It does not depend on din_valid. It depends on din_sel, so a producer must hold
//   din_sel stable while din_valid is high.
//  Latency: an accepted beat appears on dout<sel> with dout_valid[sel]=1 on the
//   next cycle. Throughput is 1 beat/cycle per channel when the consumer is always ready.
//  Per-channel slot next state, in priority order:
//   flush       -> valid=0; data unchanged
//   load & pop  -> valid=1; data=din (slot replaced in the same cycle)
//   load        -> valid=1; data=din
//   pop         -> valid=0; data unchanged
//   else        -> hold
//   load = din_valid & din_ready & (din_sel==i); pop = dout_valid[i] & dout_ready[i].
//  Channels are independent: a full, stalled channel never blocks a beat sent to
//   another channel.
//  Full slot with consumer not ready: din_ready=0 for that sel. dout and
//   dout_valid must stay stable until the beat is consumed.
//  Simultaneous flush & din_valid: the input beat is not accepted (din_ready=0).
//   Pops asserted in the same cycle are lost. Consumers treat flush as discard.
//  No beat is ever duplicated, dropped (except by flush/rst), or reordered within a channel.
//  dout data registers are not cleared by flush, only by rst.
// STRUCTURE
//  Shared package eb_pkg: DEMUX_CH=4, default W=8, channel index localparams
//   CH_WB=0, CH_MEM=1, CH_PC=2, CH_DBG=3.
//  Sub-module demux_slot (W): a one-entry register with load, pop and flush inputs,
//   and data and valid outputs. Instantiated 4x via generate.
//  Top level holds only the sel decode and the din_ready/busy logic.
// TESTING
//  1 Reset: assert rst mid-run with slots full -> all dout_valid=0, dout0..3=0,
//    busy=0 asynchronously; din_ready=0 while rst is high.
//  2 Basic route: din=8'hA5, sel=2, valid 1 cycle, all ready=0 -> next cycle
//    dout2=A5, dout_valid=4'b0100; dout_valid stays 4'b0100 until dout_ready[2]=1,
//    then 4'b0000 on the following cycle.
//  3 Back-pressure: ch1 full, dout_ready[1]=0, din sel=1 -> din_ready=0, dout1 stable.
//    Switch sel=3 -> din_ready=1 and ch3 loads.
//  4 Pass-through: ch0 full, dout_ready[0]=1 held, stream 8'h01..8'h10 to sel=0 ->
//    one beat/cycle, output sequence 01..10 in order, no gaps after the first.
//  5 Flush: ch0, ch2 full, flush=1 with din_valid=1, sel=1 -> din_ready=0;
//    dout_valid=4'b0000 next cycle; ch1 not loaded.
//  6 Random: constrained-random valid/sel/ready/flush over 10k cycles; a scoreboard
//    queue per channel checks order and no loss/duplication outside flush.

Source files
------------

// File: rtl/eb_pkg.sv
// Shared definitions for the EB result fan-out datapath.
// Channel indices name the four consumers of the result bus.
package eb_pkg;

  localparam int DEMUX_CH  = 4;
  localparam int W_DEFAULT = 8;

  localparam int CH_WB  = 0;  // register write-back
  localparam int CH_MEM = 1;  // memory
  localparam int CH_PC  = 2;  // program counter
  localparam int CH_DBG = 3;  // debug

  typedef logic [1:0] ch_sel_t;

  // One-hot decode of a channel select.
  function automatic logic [DEMUX_CH-1:0] sel_decode(input ch_sel_t sel);
    logic [DEMUX_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Priority: flush clears valid, then load (wins over a same-cycle pop,
// which replaces the slot contents), then pop. Data is only cleared by rst.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic         valid
);

  // Slot state update: flush > load > pop > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every port.
// Fans one result beat out to the write-back, memory, PC or debug consumer.
// Each channel owns an independent one-entry slot, so a stalled consumer
// only back-pressures beats addressed to its own channel.
module demux4_stream
  import eb_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [W-1:0]        din,
  input  logic [1:0]          din_sel,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [W-1:0]        dout0,
  output logic [W-1:0]        dout1,
  output logic [W-1:0]        dout2,
  output logic [W-1:0]        dout3,
  output logic [DEMUX_CH-1:0] dout_valid,
  input  logic [DEMUX_CH-1:0] dout_ready,
  output logic                busy
);

  logic [DEMUX_CH-1:0] sel_oh;
  logic [DEMUX_CH-1:0] load;
  logic [DEMUX_CH-1:0] pop;
  logic [DEMUX_CH-1:0] slot_valid;
  logic [W-1:0]        slot_data [DEMUX_CH];

  // Ready looks only at the selected slot: free, or draining this cycle.
  // Held low during reset and flush so no beat is taken while slots clear.
  always_comb begin
    sel_oh    = sel_decode(din_sel);
    din_ready = !rst && !flush &&
                (!slot_valid[din_sel] || dout_ready[din_sel]);
    load      = sel_oh & {DEMUX_CH{din_valid & din_ready}};
    pop       = slot_valid & dout_ready;
  end

  for (genvar i = 0; i < DEMUX_CH; i++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (load[i]),
      .pop   (pop[i]),
      .din   (din),
      .data  (slot_data[i]),
      .valid (slot_valid[i])
    );
  end

  assign dout0      = slot_data[CH_WB];
  assign dout1      = slot_data[CH_MEM];
  assign dout2      = slot_data[CH_PC];
  assign dout3      = slot_data[CH_DBG];
  assign dout_valid = slot_valid;
  assign busy       = |slot_valid;

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus a
// constrained-random run against per-channel scoreboard queues.
module tb_demux4_stream;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] din;
  logic [1:0] din_sel;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout0, dout1, dout2, dout3;
  logic [3:0] dout_valid;
  logic [3:0] dout_ready;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sbq [0:3][$];

  demux4_stream #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .din        (din),
    .din_sel    (din_sel),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout0      (dout0),
    .dout1      (dout1),
    .dout2      (dout2),
    .dout3      (dout3),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dout_at(input int ch);
    case (ch)
      0:       return dout0;
      1:       return dout1;
      2:       return dout2;
      default: return dout3;
    endcase
  endfunction

  task automatic idle();
    din_valid  = 1'b0;
    flush      = 1'b0;
    dout_ready = 4'b0000;
  endtask

  task automatic drive_beat(input logic [1:0] sel, input logic [7:0] d);
    @(posedge clk); #1;
    din = d; din_sel = sel; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    din = 8'h00; din_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1 din_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got=%b exp=%b", dout_valid, 4'b0000); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({dout0, dout1, dout2, dout3} !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {dout0, dout1, dout2, dout3}); end
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
    din_valid = 1'b0;
    rst = 1'b0;
    for (int ch = 0; ch < 4; ch++) drive_beat(2'(ch), 8'h10 + 8'(ch));
    @(negedge clk);
    n_cmp++; if (dout_valid !== 4'b1111) begin n_fail++; $display("FAIL fill_valid got=%b exp=%b", dout_valid, 4'b1111); end
    n_cmp++; if (dout2 !== 8'h12) begin n_fail++; $display("FAIL fill_dout2 got=%h exp=12", dout2); end
    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    din_valid = 1'b1; din_sel = 2'd1;
    #1;
    n_cmp++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL async_rst_valid got=%b exp=%b", dout_valid, 4'b0000); end
    n_cmp++; if ({dout0, dout1, dout2, dout3} !== 32'h0) begin n_fail++; $display("FAIL async_rst_data got=%h exp=0", {dout0, dout1, dout2, dout3}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_din_ready got=%b exp=0", din_ready); end
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_route();
    idle();
    drive_beat(2'd2, 8'hA5);
    @(negedge clk);
    n_cmp++; if (dout2 !== 8'hA5) begin n_fail++; $display("FAIL route_dout2 got=%h exp=a5", dout2); end
    n_cmp++; if (dout_valid !== 4'b0100) begin n_fail++; $display("FAIL route_valid got=%b exp=%b", dout_valid, 4'b0100); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (dout_valid !== 4'b0100) begin n_fail++; $display("FAIL route_hold%0d got=%b exp=%b", k, dout_valid, 4'b0100); end
    end
    @(posedge clk); #1 dout_ready = 4'b0100;
    @(negedge clk);
    n_cmp++; if (dout_valid !== 4'b0100) begin n_fail++; $display("FAIL route_pop_cycle got=%b exp=%b", dout_valid, 4'b0100); end
    @(posedge clk); #1 dout_ready = 4'b0000;
    @(negedge clk);
    n_cmp++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL route_popped got=%b exp=%b", dout_valid, 4'b0000); end
  endtask

  task automatic test_back_pressure();
    idle();
    drive_beat(2'd1, 8'h3C);
    @(posedge clk); #1;
    din = 8'h77; din_sel = 2'd1; din_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got=%b exp=0", k, din_ready); end
      n_cmp++; if (dout1 !== 8'h3C || dout_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_stable%0d got=%h/%b exp=3c/0010", k, dout1, dout_valid); end
      @(posedge clk); #1;
    end
    din_sel = 2'd3;
    @(negedge clk);
    n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready got=%b exp=1", din_ready); end
    @(posedge clk); #1 din_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dout3 !== 8'h77 || dout_valid !== 4'b1010) begin n_fail++; $display("FAIL bp_other_load got=%h/%b exp=77/1010", dout3, dout_valid); end
    n_cmp++; if (dout1 !== 8'h3C) begin n_fail++; $display("FAIL bp_ch1_kept got=%h exp=3c", dout1); end
    @(posedge clk); #1 dout_ready = 4'b1111;
    @(posedge clk); #1 dout_ready = 4'b0000;
  endtask

  task automatic test_pass_through();
    logic [7:0] q0 [$];
    logic [7:0] exp;
    idle();
    drive_beat(2'd0, 8'hEE);
    q0.push_back(8'hEE);
    @(posedge clk); #1 dout_ready = 4'b0001;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < 16) begin din = 8'(k + 1); din_sel = 2'd0; din_valid = 1'b1; end
      else din_valid = 1'b0;
      @(negedge clk);
      if (k < 16) begin
        n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL pt_ready%0d got=%b exp=1", k, din_ready); end
      end
      if (k < 17) begin
        n_cmp++; if (dout_valid[0] !== 1'b1) begin n_fail++; $display("FAIL pt_gap%0d got=%b exp=1", k, dout_valid[0]); end
      end else begin
        n_cmp++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL pt_drained got=%b exp=0000", dout_valid); end
      end
      if (dout_valid[0] === 1'b1) begin
        exp = (q0.size() != 0) ? q0.pop_front() : 8'hXX;
        n_cmp++; if (dout0 !== exp) begin n_fail++; $display("FAIL pt_order%0d got=%h exp=%h", k, dout0, exp); end
      end
      if (k < 16) q0.push_back(8'(k + 1));
    end
    idle();
  endtask

  task automatic test_flush();
    idle();
    drive_beat(2'd0, 8'h11);
    drive_beat(2'd2, 8'h22);
    @(posedge clk); #1;
    flush = 1'b1; din_valid = 1'b1; din_sel = 2'd1; din = 8'h99;
    @(negedge clk);
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", din_ready); end
    n_cmp++; if (dout_valid !== 4'b0101) begin n_fail++; $display("FAIL flush_pre_valid got=%b exp=0101", dout_valid); end
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dout_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_cleared got=%b/%b exp=0000/0", dout_valid, busy); end
    n_cmp++; if (dout1 === 8'h99) begin n_fail++; $display("FAIL flush_ch1_loaded got=%h exp=not 99", dout1); end
    n_cmp++; if (dout0 !== 8'h11 || dout2 !== 8'h22) begin n_fail++; $display("FAIL flush_data_kept got=%h/%h exp=11/22", dout0, dout2); end
  endtask

  task automatic test_random();
    logic       hold;
    logic [3:0] mv;
    logic       exp_ready;
    idle();
    for (int c = 0; c < 4; c++) sbq[c].delete();
    hold = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      if (!hold) begin
        din_valid = ($urandom_range(0, 2) != 0);
        din_sel   = 2'($urandom_range(0, 3));
        din       = 8'($urandom);
      end
      flush      = ($urandom_range(0, 31) == 0);
      dout_ready = 4'($urandom);
      @(negedge clk);
      for (int c = 0; c < 4; c++) mv[c] = (sbq[c].size() != 0);
      exp_ready = !flush && (!mv[din_sel] || dout_ready[din_sel]);
      n_cmp++; if (din_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, din_ready, exp_ready); end
      n_cmp++; if (dout_valid !== mv) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, mv); end
      n_cmp++; if (busy !== (|mv)) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, |mv); end
      for (int c = 0; c < 4; c++) begin
        if (mv[c]) begin
          n_cmp++; if (dout_at(c) !== sbq[c][0]) begin n_fail++; $display("FAIL rnd_data ch=%0d cyc=%0d got=%h exp=%h", c, cyc, dout_at(c), sbq[c][0]); end
        end
      end
      if (flush) begin
        for (int c = 0; c < 4; c++) sbq[c].delete();
      end else begin
        for (int c = 0; c < 4; c++) if (mv[c] && dout_ready[c]) void'(sbq[c].pop_front());
        if (din_valid && exp_ready) sbq[din_sel].push_back(din);
      end
      hold = din_valid && !exp_ready;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = '0; din_sel = '0; din_valid = 1'b0; dout_ready = '0;
    test_reset();
    test_basic_route();
    test_back_pressure();
    test_pass_through();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
